// File: rtl/countdown_ctrl.sv
// LED-bar countdown controller: self-timed tick, start/pause/abort/clear, sticky lockout on expiry.
// Optional build macro COUNTDOWN_BLINK_EN: bar blinks on every tick while EXPIRED.
module countdown_ctrl #(
   parameter int TICK_DIV = 25000000,
   parameter int N_LED    = 11
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             clear,
   output logic [N_LED-1:0] led,
   output logic [3:0]       remaining,
   output logic             busy,
   output logic             loa,
   output logic             expired
);

   localparam int             TW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]  TCNT_MAX = TW'(TICK_DIV - 1);
   localparam logic [3:0]     N_CNT    = 4'(N_LED);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

   state_t           state_q;
   logic [TW-1:0]    tcnt_q;
   logic [3:0]       rem_q;
   logic [N_LED-1:0] led_q;
   logic             busy_q;
   logic             loa_q;
   logic             exp_q;

   logic             tick;
   logic [TW-1:0]    tcnt_d;
   logic [3:0]       rem_d;

   function automatic logic [N_LED-1:0] thermo(input logic [3:0] n);
      logic [N_LED-1:0] t;
      for (int i = 0; i < N_LED; i++) t[i] = (i < int'(n));
      return t;
   endfunction

   assign tick   = (tcnt_q == TCNT_MAX);
   assign tcnt_d = tick ? '0 : tcnt_q + TW'(1);
   assign rem_d  = rem_q - 4'd1;

   // PAUSE with pause low behaves exactly like RUN, so a pause of P cycles delays expiry by P.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         tcnt_q  <= '0;
         rem_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         loa_q   <= 1'b0;
         exp_q   <= 1'b0;
      end else begin
         exp_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q <= S_RUN;
                  tcnt_q  <= '0;
                  rem_q   <= N_CNT;
                  led_q   <= '1;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN, S_PAUSE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  tcnt_q  <= '0;
                  rem_q   <= '0;
                  led_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (pause) begin
                  state_q <= S_PAUSE;
               end else begin
                  state_q <= S_RUN;
                  tcnt_q  <= tcnt_d;
                  if (tick) begin
                     if (rem_q > 4'd1) begin
                        rem_q <= rem_d;
                        led_q <= thermo(rem_d);
                     end else begin
                        state_q <= S_EXPIRED;
                        rem_q   <= '0;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                        loa_q   <= 1'b1;
                        exp_q   <= 1'b1;
                     end
                  end
               end
            end
            S_EXPIRED: begin
               if (clear) begin
                  state_q <= S_IDLE;
                  tcnt_q  <= '0;
                  led_q   <= '0;
                  loa_q   <= 1'b0;
               end else begin
`ifdef COUNTDOWN_BLINK_EN
                  tcnt_q <= tcnt_d;
                  if (tick) led_q <= ~led_q;
`else
                  tcnt_q <= '0;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign led       = led_q;
   assign remaining = rem_q;
   assign busy      = busy_q;
   assign loa       = loa_q;
   assign expired   = exp_q;

endmodule
